// File: rtl/uart_rx_port.sv
// -----------------------------------------------------------------------------
// uart_rx_port
//   Memory-mapped serial input port. Receives UART frames on one pin and holds
//   the received byte plus status flags for the CPU to read.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     undefined : 8N1 frames, parity_err always reads 0
//     defined   : 8E1 frames, a parity mismatch sets parity_err and drops the byte
//
// Ports
//   clock      in   1   system clock, all state on rising edge
//   reset_n    in   1   asynchronous active-low reset
//   rx_in      in   1   asynchronous serial line, idle high
//   rd_ack     in   1   one-cycle pulse: CPU has consumed out_data
//   out_data   out  32  {24'b0, rx_byte}
//   state_reg  out  32  {27'b0, parity_err, busy, frame_err, overrun, valid}
// -----------------------------------------------------------------------------
module uart_rx_port #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_in,
  input  logic        rd_ack,
  output logic [31:0] out_data,
  output logic [31:0] state_reg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_C = CW'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   rx_prev_q;
  logic                   rx_s;
  logic                   sync_full_s;
  logic                   fall_s;

  state_e          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;
  logic            parity_err_s;
`ifdef UART_RX_PARITY_EN
  logic            parity_err_q, parity_err_d;
  logic            par_bad_q, par_bad_d;
`endif

  assign rx_s        = sync_q[SYNC_STAGES-1];
  // fill_q marks when the chain holds real line samples rather than the reset
  // preset, so a line held low through reset is never seen as a falling edge.
  assign sync_full_s = fill_q[SYNC_STAGES-1];
  assign fall_s      = sync_full_s & rx_prev_q & ~rx_s;

  // Input synchroniser, fill tracker and previous-sample register for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= {SYNC_STAGES{1'b1}};
      fill_q    <= {SYNC_STAGES{1'b0}};
      rx_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_in};
      fill_q    <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      rx_prev_q <= sync_full_s & rx_s;
    end
  end

  // Receiver FSM state and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      rx_byte_q    <= 8'h00;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
      par_bad_q    <= par_bad_d;
`endif
    end
  end

  // Next-state, sampling and status-flag logic.
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
    frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
    par_bad_d    = par_bad_q;
`endif

    // Acknowledge clears flags first; a stop-bit event below may then set them
    // again, so a byte arriving in the ack cycle loads cleanly without overrun.
    if (rd_ack && valid_q) begin
      valid_d      = 1'b0;
      overrun_d    = 1'b0;
      frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end else begin
      valid_d      = valid_q;
    end

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (fall_s) begin
          state_d = S_START;
          bit_d   = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_q == HALF_C) begin
          baud_d  = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == FULL_C) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (baud_q == FULL_C) begin
          baud_d    = '0;
          par_bad_d = ^{shift_q, rx_s};
          state_d   = S_STOP;
        end else begin
          baud_d    = baud_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_q == FULL_C) begin
          baud_d  = '0;
          state_d = S_IDLE;
          if (!rx_s) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            parity_err_d = 1'b1;
`endif
          end else if (valid_q && !rd_ack) begin
            overrun_d = 1'b1;
          end else begin
            rx_byte_d = shift_q;
            valid_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err_s = parity_err_q;
`else
  assign parity_err_s = 1'b0;
`endif

  assign out_data  = {24'h000000, rx_byte_q};
  assign state_reg = {27'h0000000, parity_err_s, (state_q != S_IDLE),
                      frame_err_q, overrun_q, valid_q};

endmodule

// File: tb/tb_uart_rx_port.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_port
//   Directed bench for uart_rx_port (CLKS_PER_BIT=16, SYNC_STAGES=2).
//   Stimulus pushes the expected {out_data, state_reg} for each visible change;
//   a monitor pops and compares whenever the non-busy outputs change.
// -----------------------------------------------------------------------------
module tb_uart_rx_port;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // 2 sync flops + 1 edge-detect cycle + half bit + remaining bits up to stop sample,
  // then valid rises on the next edge.
  localparam int LAT = 3 + CPB / 2 + (NBITS - 1) * CPB;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_in = 1'b1;
  logic        rd_ack = 1'b0;
  logic [31:0] out_data;
  logic [31:0] state_reg;

  uart_rx_port #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx_in    (rx_in),
    .rd_ack   (rd_ack),
    .out_data (out_data),
    .state_reg(state_reg)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic [31:0] s;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int start_cyc = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] s);
    exp_t e;
    e.d = d;
    e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    idle(1);
    rd_ack = 1'b0;
    idle(2);
  endtask

  // Sends one frame; par_flip inverts the even-parity bit, ack_at_stop pulses
  // rd_ack so it is sampled on the stop-bit sample edge.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic par_flip, input logic ack_at_stop);
    logic [10:0] bits;
    bits    = 11'h7FF;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (NBITS == 11) begin
      bits[9]  = (^d) ^ par_flip;
      bits[10] = stop;
    end else begin
      bits[9]  = stop;
    end
    start_cyc = cyc;
    for (int i = 0; i < NBITS * CPB; i++) begin
      rx_in  = bits[i / CPB];
      rd_ack = ack_at_stop && (i == LAT - 1);
      @(posedge clock);
      #1;
    end
    rx_in  = 1'b1;
    rd_ack = 1'b0;
    idle(4);
  endtask

  // Monitor: compares every change of the non-busy outputs against the queue.
  initial begin
    logic [31:0] last_d, last_s;
    logic        last_v;
    exp_t        e;
    wait (mon_en);
    last_d = out_data;
    last_s = state_reg & ~32'h0000_0008;
    last_v = state_reg[0];
    forever begin
      @(negedge clock);
      if (!last_v && state_reg[0])
        check("latency", 32'(cyc - start_cyc), 32'(LAT));
      if (out_data !== last_d || (state_reg & ~32'h0000_0008) !== last_s) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected: got data %h state %h, nothing expected", out_data, state_reg);
        end else begin
          e = exp_q.pop_front();
          check("mon_data", out_data, e.d);
          check("mon_state", state_reg, e.s);
        end
      end
      last_d = out_data;
      last_s = state_reg & ~32'h0000_0008;
      last_v = state_reg[0];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    #1;
    check("rst_data", out_data, 32'h0);
    check("rst_state", state_reg, 32'h0);
    idle(2);
    reset_n = 1'b1;
    idle(6);
    mon_en = 1'b1;
    idle(2);

    // 1: single byte
    push(32'hA5, 32'h1);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    push(32'hA5, 32'h0);
    ack();

    // 2: overrun
    push(32'h3C, 32'h1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    push(32'h3C, 32'h3);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    push(32'h3C, 32'h0);
    ack();

    // 3: framing error then a good byte (frame_err sticky until ack)
    push(32'h3C, 32'h4);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    push(32'h12, 32'h5);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    push(32'h12, 32'h0);
    ack();

    // 4: 4-cycle glitch on idle line
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      idle(1);
      if (state_reg[3]) busy_cnt++;
    end
    check("glitch_busy_seen", 32'(busy_cnt > 0), 32'h1);
    check("glitch_busy_short", 32'(busy_cnt < 12), 32'h1);
    check("glitch_state", state_reg, 32'h0);
    check("glitch_data", out_data, 32'h12);

    // 5: rd_ack in the stop-sample cycle while a byte is held
    push(32'h40, 32'h1);
    send_frame(8'h40, 1'b1, 1'b0, 1'b0);
    push(32'h81, 32'h1);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    push(32'h81, 32'h0);
    ack();

    // Reset mid-frame with the line held low through and after reset
    push(32'h0, 32'h0);
    rx_in = 1'b0;
    idle(40);
    reset_n = 1'b0;
    #1;
    check("midrst_data", out_data, 32'h0);
    check("midrst_state", state_reg, 32'h0);
    idle(3);
    reset_n = 1'b1;
    idle(40);
    check("low_line_no_frame", state_reg, 32'h0);
    rx_in = 1'b1;
    idle(20);
    push(32'h5A, 32'h1);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    // 6: parity good then bad
    push(32'h5A, 32'h0);
    ack();
    push(32'h07, 32'h1);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    push(32'h07, 32'h0);
    ack();
    push(32'h07, 32'h10);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
`endif

    idle(20);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
